// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 multiply sequencer time-sharing one 16x16 core over four partial products
module mul_seq_ctrl #(
  parameter int MUL_PIPE = 1,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [1:0]          start_op,
  input  logic [RESULT_W-1:0] src_a,
  input  logic [RESULT_W-1:0] src_b,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [RESULT_W-1:0] result_data,
  output logic                busy
);
  // ISSUE states have bit 2 set; bits [1:0] pick the operand halves (bit0: a high, bit1: b high)
  typedef enum logic [2:0] {
    IDLE = 3'd0, DRAIN = 3'd1, SIGN = 3'd2, DONE = 3'd3,
    ISSUE0 = 3'd4, ISSUE1 = 3'd5, ISSUE2 = 3'd6, ISSUE3 = 3'd7
  } state_t;
  state_t state, nxt;
  logic accept, a_neg, b_neg, neg;
  logic [31:0] a, b, p1, p2, prod;
  logic [15:0] x, y;
  logic [1:0] op, cnt, s1, s2, ps;
  logic v1, v2, pv;
  logic [63:0] acc, acc_s, pe, term;
  assign accept = start_valid && start_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE   ? (accept ? ISSUE0 : IDLE)
        : state == ISSUE3 ? DRAIN
        : state[2]        ? state_t'(state + 3'd1)
        : state == DRAIN  ? (cnt == 2'(MUL_PIPE - 1) ? SIGN : DRAIN)
        : state == SIGN   ? DONE
        : (result_ready ? IDLE : DONE);
  always_comb begin
    start_ready  = state == IDLE;
    busy         = state != IDLE;
    result_valid = state == DONE;
  end
  always_comb begin
    a_neg = (start_op == 2'd1 || start_op == 2'd2) && src_a[31];
    b_neg = start_op == 2'd1 && src_b[31];
    x     = state[0] ? a[31:16] : a[15:0];
    y     = state[1] ? b[31:16] : b[15:0];
    prod  = MUL_PIPE == 2 ? p2 : p1;
    pv    = MUL_PIPE == 2 ? v2 : v1;
    ps    = MUL_PIPE == 2 ? s2 : s1;
    pe    = {32'b0, prod};
    term  = ps == 2'd0 ? pe : ps == 2'd3 ? pe << 32 : pe << 16;
    acc_s = neg ? -acc : acc;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a           <= '0;
      b           <= '0;
      op          <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      p1          <= '0;
      p2          <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      s1          <= '0;
      s2          <= '0;
      acc         <= '0;
      result_data <= '0;
    end else begin
      cnt <= state == DRAIN ? cnt + 2'd1 : 2'd0;
      p1  <= {16'b0, x} * {16'b0, y};
      v1  <= state[2];
      s1  <= state[1:0];
      p2  <= p1;
      v2  <= v1;
      s2  <= s1;
      if (accept) begin
        a   <= a_neg ? -src_a : src_a;
        b   <= b_neg ? -src_b : src_b;
        op  <= start_op;
        neg <= a_neg ^ b_neg;
        acc <= '0;
      end else if (pv) acc <= acc + term;
      if (state == SIGN) result_data <= op == 2'd0 ? acc_s[31:0] : acc_s[63:32];
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that computes 32x32 products for the CPU custom/multiply path.
- Time-shares one embedded 16x16 unsigned multiplier over four partial products and accumulates them into a 64-bit sum.
- Handles signed and unsigned operand modes.
- Returns the low or high word through a valid/ready handshake.

Parameters:
- MUL_PIPE, 1: register stages inside the embedded 16x16 multiplier; legal values 1 or 2.
- RESULT_W, 32: operand and result width. Fixed at 32; any other value is illegal.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start_valid, input, 1: request present.
- start_ready, output, 1: block can accept a request.
- start_op, input, 2: operation select. 0 = MUL (low 32), 1 = MULH (signed x signed, high 32), 2 = MULHSU (signed a x unsigned b, high 32), 3 = MULHU (unsigned x unsigned, high 32).
- src_a, input, 32: operand A.
- src_b, input, 32: operand B.
- result_valid, output, 1: result available.
- result_ready, input, 1: consumer accepts the result.
- result_data, output, 32: selected product word.
- busy, output, 1: high in any state except IDLE.

Behaviour:
- Reset (asynchronous on reset_n low):
  - State goes to IDLE; all registers go to 0.
  - Output values during reset: start_ready=1, result_valid=0, result_data=0, busy=0.
  - Reset mid-operation discards the pending operation. There is no partial output.
- Accept rule:
  - A request is accepted on a rising edge where start_valid && start_ready.
  - src_a, src_b and start_op are captured on that edge; later input changes are ignored.
- Sign handling:
  - a_neg = (op==1 || op==2) && src_a[31].
  - b_neg = (op==1) && src_b[31].
  - Operands are replaced by their 32-bit two's-complement magnitudes when negative. The magnitude of 0x80000000 is 0x80000000 (unsigned).
  - neg = a_neg ^ b_neg.
  - MUL treats both operands as unsigned; the low 32 bits are sign-independent.
- States: IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, DRAIN, SIGN, DONE.
  - IDLE -> ISSUE0 on accept.
  - ISSUE0..ISSUE3 each drive one partial-product pair into the multiplier, in order: aL*bL (shift 0), aH*bL (shift 16), aL*bH (shift 16), aH*bH (shift 32).
  - A 64-bit accumulator adds each product at its shift MUL_PIPE cycles after issue.
  - The accumulator is cleared on accept.
  - DRAIN lasts MUL_PIPE cycles (a counter) until the last product is accumulated.
  - SIGN: if neg, the 64-bit two's complement of the accumulator is taken. result_data is then registered: acc[31:0] for op 0, acc[63:32] otherwise.
  - SIGN -> DONE.
  - DONE: result_valid=1. DONE -> IDLE on result_ready.
- Latency is fixed and independent of operands and op.
  - Accept at edge k gives result_valid high from edge k+5+MUL_PIPE (k+6 for the default).
- Throughput: one operation per 7+MUL_PIPE cycles minimum.
  - start_ready is high only in IDLE, so no new request is taken in the DONE cycle.
- Backpressure:
  - While result_valid && !result_ready, result_data is held stable and the block stays in DONE.
  - start_valid is ignored during DONE.
- result_data is held after the handshake until the next SIGN state.
- Multiplier enable is constant. The multiplier registers clear on reset.
- No overflow is possible: the 64-bit accumulator holds the full product.

Test Plan:
- MUL, a=0x00010003, b=0x00020005, accepted at edge k, result_ready=1 -> result_valid at edge k+6 for one cycle, result_data=0x000B000F; start_ready returns high the next cycle.
- MULHU, a=b=0xFFFFFFFF -> result_data=0xFFFFFFFE. A following MUL with the same operands -> 0x00000001.
- MULH, a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF. MULH, a=b=0x80000000 -> 0x40000000.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHSU, a=0x00000002, b=0x80000000 -> 0x00000001.
- Backpressure: hold result_ready=0 for 10 cycles with start_valid=1 and new operands -> result_valid and result_data stable, start_ready=0, busy=1, no second accept. After result_ready pulses, the second request is accepted the next cycle and produces a correct result.
- Reset: drop reset_n during ISSUE2 -> all outputs reset immediately, start_ready=1. After release, a MULHU 0x00010000*0x00010000 -> 0x00000001. Repeat the directed cases with MUL_PIPE=2 -> latency 7.
